// File: rtl/sine_width_if.sv
// Bus between the tick/frequency source and the sine width generator.
// SINE_AMP_SCALE_EN adds the 8-bit amplitude word.
interface sine_width_if #(
    parameter int PHASE_W = 32,
    parameter int WIDTH_W = 32
);
    logic               en;
    logic               tick;
    logic [PHASE_W-1:0] phase_inc;
`ifdef SINE_AMP_SCALE_EN
    logic [7:0]         amp;
`endif
    logic [WIDTH_W-1:0] width;
    logic               width_stb;

    modport master (
        output en, tick, phase_inc,
`ifdef SINE_AMP_SCALE_EN
        output amp,
`endif
        input  width, width_stb
    );

    modport slave (
        input  en, tick, phase_inc,
`ifdef SINE_AMP_SCALE_EN
        input  amp,
`endif
        output width, width_stb
    );
endinterface

// File: rtl/sine_width_gen.sv
// Per-PWM-period duty width from a phase-accumulator DDS with a quarter-wave LUT.
// SINE_AMP_SCALE_EN adds amplitude scaling (one extra stage, latency 4 instead of 3).
module sine_width_gen #(
    parameter int PWM_PERIOD = 1000,
    parameter int ADDR_W     = 8,
    parameter int PHASE_W    = 32,
    parameter int WIDTH_W    = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    sine_width_if.slave  bus
);
    localparam int  MID       = PWM_PERIOD / 2;
    localparam int  LUT_DEPTH = 1 << ADDR_W;
    localparam int  QW        = $clog2(MID);
    localparam real PI        = 3.14159265358979323846;
`ifdef SINE_AMP_SCALE_EN
    localparam int  STAGES    = 4;
`else
    localparam int  STAGES    = 3;
`endif

    // Quarter-wave table, sampled at bin centres so no entry is 0 or MID.
    logic [LUT_DEPTH-1:0][QW-1:0] w_lut;
    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        localparam real ANG = PI / 2.0 * (real'(k) + 0.5) / real'(LUT_DEPTH);
        localparam int  QV  = $rtoi(real'(MID - 1) * $sin(ANG) + 0.5);
        assign w_lut[k] = QW'(QV);
    end

    logic                 w_accept;
    logic [ADDR_W+1:0]    w_idx;
    logic [PHASE_W-1:0]   r_phase;
    logic [STAGES:1]      r_vld_pipe;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_neg1, r_neg2;
    logic [QW-1:0]        r_q2;
    logic [QW-1:0]        w_mag;
    logic                 w_neg;
    logic [WIDTH_W-1:0]   w_width;
    logic [WIDTH_W-1:0]   r_width;

    assign w_accept = bus.tick & bus.en;
    assign w_idx    = r_phase[PHASE_W-1 -: ADDR_W+2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_accept};
            if (w_accept)
                r_phase <= r_phase + bus.phase_inc;
        end
    end

    // S1: odd quadrants read the table mirrored (LUT_DEPTH-1-a == ~a).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_neg1 <= 1'b0;
        end else if (w_accept) begin
            r_addr <= w_idx[ADDR_W] ? ~w_idx[ADDR_W-1:0] : w_idx[ADDR_W-1:0];
            r_neg1 <= w_idx[ADDR_W+1];
        end
    end

    // S2: synchronous ROM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q2   <= '0;
            r_neg2 <= 1'b0;
        end else begin
            r_q2   <= w_lut[r_addr];
            r_neg2 <= r_neg1;
        end
    end

`ifdef SINE_AMP_SCALE_EN
    logic [7:0]    r_amp1, r_amp2;
    logic [QW+7:0] w_prod;
    logic [QW-1:0] r_q3;
    logic          r_neg3;

    assign w_prod = (QW+8)'(r_q2) * (QW+8)'(r_amp2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_amp1 <= '0;
            r_amp2 <= '0;
            r_q3   <= '0;
            r_neg3 <= 1'b0;
        end else begin
            if (w_accept)
                r_amp1 <= bus.amp;
            r_amp2 <= r_amp1;
            r_q3   <= w_prod[QW+7:8];
            r_neg3 <= r_neg2;
        end
    end

    assign w_mag = r_q3;
    assign w_neg = r_neg3;
`else
    assign w_mag = r_q2;
    assign w_neg = r_neg2;
`endif

    assign w_width = w_neg ? WIDTH_W'(MID) - WIDTH_W'(w_mag)
                           : WIDTH_W'(MID) + WIDTH_W'(w_mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_width <= WIDTH_W'(MID);
        else if (r_vld_pipe[STAGES-1])
            r_width <= w_width;
    end

    assign bus.width     = r_width;
    assign bus.width_stb = r_vld_pipe[STAGES];
endmodule

// File: tb/tb_sine_width_gen.sv
// Randomized bench for sine_width_gen against a sin()-based reference model.
// Build with +define+SINE_AMP_SCALE_EN to exercise the amplitude option.
module tb_sine_width_gen;
    localparam int PWM     = 1000;
    localparam int ADDR_W  = 8;
    localparam int PHASE_W = 32;
    localparam int WIDTH_W = 32;
    localparam int MID     = PWM / 2;
    localparam int D       = 1 << ADDR_W;
    localparam real PI     = 3.14159265358979323846;
`ifdef SINE_AMP_SCALE_EN
    localparam int LAT     = 4;
    localparam int DIR_AMP = 128;
    int exp_seq[5] = '{501, 749, 499, 251, 501};
`else
    localparam int LAT     = 3;
    localparam int DIR_AMP = 256;
    int exp_seq[5] = '{502, 999, 498, 1, 502};
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sine_width_if #(.PHASE_W(PHASE_W), .WIDTH_W(WIDTH_W)) bus();

    sine_width_gen #(
        .PWM_PERIOD(PWM), .ADDR_W(ADDR_W), .PHASE_W(PHASE_W), .WIDTH_W(WIDTH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Width at phase bin idx: sine of the bin-centre angle over a full turn.
    function automatic int model_width(input int idx, input int amp);
        real s, m;
        int  mag;
        s   = $sin(2.0 * PI * (real'(idx) + 0.5) / real'(4 * D));
        m   = (s < 0.0) ? -s : s;
        mag = $rtoi(m * real'(MID - 1) + 0.5);
        if (amp < 256) mag = (mag * amp) >> 8;
        return (s < 0.0) ? MID - mag : MID + mag;
    endfunction

    typedef struct { int due; int val; } pend_t;
    pend_t             pend[$];
    int                obs_w[$];
    logic [PHASE_W-1:0] m_phase = '0;
    int                m_width = MID;
    int                edge_n  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = '0;
            m_width = MID;
            pend.delete();
        end else begin
            int    amp_s;
            logic  exp_stb;
            pend_t p;
`ifdef SINE_AMP_SCALE_EN
            amp_s = int'(bus.amp);
`else
            amp_s = 256;
`endif
            if (bus.tick && bus.en) begin
                p.due = edge_n + LAT - 1;
                p.val = model_width(int'(m_phase[PHASE_W-1 -: ADDR_W+2]), amp_s);
                pend.push_back(p);
                m_phase = m_phase + bus.phase_inc;
            end
            #1;
            exp_stb = (pend.size() > 0) && (pend[0].due == edge_n);
            if (exp_stb) begin
                m_width = pend[0].val;
                void'(pend.pop_front());
            end
            chk("stb", 64'(bus.width_stb), 64'(exp_stb));
            chk("width", 64'(bus.width), 64'(m_width));
            if (bus.width_stb) obs_w.push_back(int'(bus.width));
            edge_n++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
    endtask

    task automatic set_amp(input int a);
`ifdef SINE_AMP_SCALE_EN
        bus.amp = 8'(a);
`endif
    endtask

    initial begin
        int base;
        bus.en = 1'b0;
        bus.tick = 1'b0;
        bus.phase_inc = '0;
        set_amp(DIR_AMP);
        cyc(3);
        chk("rst_width", 64'(bus.width), 64'(MID));
        chk("rst_stb", 64'(bus.width_stb), 64'd0);
        rst_n = 1'b1;
        cyc(20);
        chk("idle_nostb", 64'(obs_w.size()), 64'd0);

        // single tick at phase 0
        bus.en = 1'b1;
        do_tick();
        cyc(8);
        chk("t0_cnt", 64'(obs_w.size()), 64'd1);
        if (obs_w.size() == 1) chk("t0_val", 64'(obs_w[0]), 64'(exp_seq[0]));

        // quarter-turn steps
        obs_w.delete();
        bus.phase_inc = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            do_tick();
            cyc(PWM - 2);
        end
        chk("qt_cnt", 64'(obs_w.size()), 64'd5);
        for (int i = 0; i < 5 && i < obs_w.size(); i++)
            chk($sformatf("qt_%0d", i), 64'(obs_w[i]), 64'(exp_seq[i]));

        // en low: ticks ignored, phase frozen; then en rises with a tick
        obs_w.delete();
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_tick();
            cyc(10);
        end
        chk("en_off_cnt", 64'(obs_w.size()), 64'd0);
        @(negedge clk) begin bus.en = 1'b1; bus.tick = 1'b1; end
        @(negedge clk) bus.tick = 1'b0;
        cyc(10);
        do_tick();
        cyc(10);
        chk("en_on_cnt", 64'(obs_w.size()), 64'd2);
        if (obs_w.size() == 2) begin
            chk("en_on_0", 64'(obs_w[0]), 64'(exp_seq[1]));
            chk("en_on_1", 64'(obs_w[1]), 64'(exp_seq[2]));
        end

        // reset one cycle after a tick
        obs_w.delete();
        do_tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_width", 64'(bus.width), 64'(MID));
        chk("midrst_stb", 64'(bus.width_stb), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        bus.phase_inc = '0;
        cyc(8);
        chk("midrst_nostb", 64'(obs_w.size()), 64'd0);
        do_tick();
        cyc(8);
        chk("postrst_cnt", 64'(obs_w.size()), 64'd1);
        if (obs_w.size() == 1) chk("postrst_val", 64'(obs_w[0]), 64'(exp_seq[0]));

        // randomized traffic; the checker process compares every cycle
        base = obs_w.size();
        for (int i = 0; i < 300; i++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            bus.phase_inc = $urandom();
            set_amp($urandom_range(0, 255));
            do_tick();
            bus.phase_inc = $urandom();
            set_amp($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) cyc($urandom_range(0, 2));
            else                           cyc($urandom_range(6, 18));
        end
        cyc(20);
        chk("drain", 64'(pend.size()), 64'd0);
        chk("rand_some", 64'(obs_w.size() > base + 200), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
